// File: rtl/music_player.sv
// music_player: score sequencer and square-wave tone generator.
// Steps the note ROM one beat at a time and drives the buzzer pin.
module music_player #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000,
    parameter int SCORE_LEN   = 135,
    parameter int ADDR_WIDTH  = 8,
    parameter int LOOP        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  pause,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [11:0]           rom_data,
    output logic                  buzzer,
    output logic [11:0]           note_code,
    output logic                  playing,
    output logic                  done
);

    localparam int MAX_HALF  = CLK_FREQ / (2 * 262);
    localparam int HW        = $clog2(MAX_HALF + 1);
    localparam int BW        = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_START = (GAP_CYCLES >= BEAT_CYCLES) ? 0
                             : BEAT_CYCLES - GAP_CYCLES;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [BW-1:0]         beat_cnt;
    logic [BW-1:0]         beat_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [HW-1:0]         tone_cnt;
    logic [HW-1:0]         tone_nx;
    logic [HW-1:0]         half_reg;
    logic [HW-1:0]         half_nx;
    logic [HW-1:0]         half_dec;
    logic [11:0]           note_nx;
    logic [3:0]            nib;
    logic [1:0]            oct;
    logic                  load;
    logic                  load_nx;
    logic                  ph;
    logic                  ph_nx;
    logic                  done_nx;
    logic                  gate_nx;
    logic                  run;
    logic                  beat_last;
    logic                  score_last;

    // Half-period per octave/degree, folded to constants at elaboration.
    function automatic logic [HW-1:0] half_lut(input logic [1:0] o,
                                               input logic [2:0] d);
        int h;
        case ({o, d})
            5'b00_001: h = CLK_FREQ / (2 * 262);
            5'b00_010: h = CLK_FREQ / (2 * 294);
            5'b00_011: h = CLK_FREQ / (2 * 330);
            5'b00_100: h = CLK_FREQ / (2 * 349);
            5'b00_101: h = CLK_FREQ / (2 * 392);
            5'b00_110: h = CLK_FREQ / (2 * 440);
            5'b00_111: h = CLK_FREQ / (2 * 494);
            5'b01_001: h = CLK_FREQ / (2 * 523);
            5'b01_010: h = CLK_FREQ / (2 * 587);
            5'b01_011: h = CLK_FREQ / (2 * 659);
            5'b01_100: h = CLK_FREQ / (2 * 698);
            5'b01_101: h = CLK_FREQ / (2 * 784);
            5'b01_110: h = CLK_FREQ / (2 * 880);
            5'b01_111: h = CLK_FREQ / (2 * 988);
            5'b10_001: h = CLK_FREQ / (2 * 1047);
            5'b10_010: h = CLK_FREQ / (2 * 1175);
            5'b10_011: h = CLK_FREQ / (2 * 1319);
            5'b10_100: h = CLK_FREQ / (2 * 1397);
            5'b10_101: h = CLK_FREQ / (2 * 1568);
            5'b10_110: h = CLK_FREQ / (2 * 1760);
            5'b10_111: h = CLK_FREQ / (2 * 1976);
            default:   h = 0;
        endcase
        return HW'(h);
    endfunction

    assign run        = (state == PLAY) && !stop;
    assign beat_last  = beat_cnt == BW'(BEAT_CYCLES - 1);
    assign score_last = rom_addr == ADDR_WIDTH'(SCORE_LEN - 1);

    // Note decode: first non-zero nibble wins, high over med over low.
    always_comb begin
        nib = rom_data[3:0];
        oct = 2'd0;
        unique case (1'b1)
            (rom_data[11:8] != 4'd0): begin
                nib = rom_data[11:8];
                oct = 2'd2;
            end
            (rom_data[11:8] == 4'd0 && rom_data[7:4] != 4'd0): begin
                nib = rom_data[7:4];
                oct = 2'd1;
            end
            default: begin
                nib = rom_data[3:0];
                oct = 2'd0;
            end
        endcase
        half_dec = nib[3] ? '0 : half_lut(oct, nib[2:0]);
    end

    // Sequencer next state: stop wins, then play/pause, then beat wrap.
    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        addr_nx  = rom_addr;
        load_nx  = 1'b0;
        done_nx  = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            beat_nx  = '0;
            addr_nx  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (play) begin
                        state_nx = PLAY;
                        beat_nx  = '0;
                        addr_nx  = '0;
                        load_nx  = 1'b1;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end
                    if (beat_last) begin
                        beat_nx = '0;
                        if (score_last && LOOP == 0) begin
                            state_nx = IDLE;
                            addr_nx  = '0;
                            done_nx  = 1'b1;
                        end else begin
                            addr_nx = score_last ? '0 : rom_addr + 1'b1;
                            load_nx = 1'b1;
                        end
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause || play) begin
                        state_nx = PLAY;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Tone next state: reload at beat start, else free-run while playing.
    always_comb begin
        tone_nx = tone_cnt;
        ph_nx   = ph;
        half_nx = half_reg;
        note_nx = note_code;
        if (state_nx == IDLE) begin
            tone_nx = '0;
            ph_nx   = 1'b0;
            half_nx = '0;
            note_nx = '0;
        end else if (load) begin
            tone_nx = '0;
            ph_nx   = 1'b0;
            half_nx = half_dec;
            note_nx = rom_data;
        end else if (run) begin
            if (half_reg == '0) begin
                tone_nx = '0;
            end else if (tone_cnt == half_reg - 1'b1) begin
                tone_nx = '0;
                ph_nx   = ~ph;
            end else begin
                tone_nx = tone_cnt + 1'b1;
            end
        end
        gate_nx = (state_nx == PLAY) && !load_nx && (half_nx != '0)
               && !(GAP_CYCLES != 0 && beat_nx >= BW'(GAP_START));
    end

    // Sequencer registers and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rom_addr <= '0;
            load     <= 1'b0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
            rom_addr <= addr_nx;
            load     <= load_nx;
            playing  <= state_nx != IDLE;
            done     <= done_nx;
        end
    end

    // Tone registers; buzzer is the gated phase, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt  <= '0;
            half_reg  <= '0;
            ph        <= 1'b0;
            note_code <= '0;
            buzzer    <= 1'b0;
        end else begin
            tone_cnt  <= tone_nx;
            half_reg  <= half_nx;
            ph        <= ph_nx;
            note_code <= note_nx;
            buzzer    <= ph_nx & gate_nx;
        end
    end

endmodule
